// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_byte_tx among NUM_REQ byte producers.
// Latches the winner's byte, holds Send_Go until Tx_done (or timeout), then pulses done.
module uart_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic                 clk,
    input  logic                 n_reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   grant,
    output logic [NUM_REQ-1:0]   done,
    output logic [7:0]           tx_data,
    output logic                 send_go,
    input  logic                 tx_done,
    output logic                 timeout_err,
    output logic                 busy
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [23:0] TO_LAST = (TIMEOUT_CYC == 0) ? 24'd0 : 24'(TIMEOUT_CYC - 1);
    localparam logic [IW-1:0] LAST_RST = IW'(NUM_REQ - 1);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    state_t              state_q, state_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [NUM_REQ-1:0]  done_q, done_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                send_go_q, send_go_d;
    logic                timeout_err_q, timeout_err_d;
    logic [IW-1:0]       last_q, last_d;
    logic [23:0]         cnt_q, cnt_d;

    logic                found;
    logic [IW-1:0]       win;
    int                  rr_idx;
    logic                timeout_hit;

    // Search starts just after the last winner so every requester gets a turn.
    always_comb begin
        found  = 1'b0;
        win    = '0;
        rr_idx = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            rr_idx = (int'(last_q) + k) % NUM_REQ;
            if (!found && req[rr_idx]) begin
                found = 1'b1;
                win   = IW'(rr_idx);
            end
        end
    end

    assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_q == TO_LAST);

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        done_d        = '0;
        tx_data_d     = tx_data_q;
        send_go_d     = send_go_q;
        timeout_err_d = 1'b0;
        last_d        = last_q;
        cnt_d         = cnt_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d      = '0;
                    grant_d[win] = 1'b1;
                    tx_data_d    = req_data[int'(win)*8 +: 8];
                    send_go_d    = 1'b1;
                    last_d       = win;
                    cnt_d        = '0;
                    state_d      = SEND;
                end
            end
            SEND: begin
                cnt_d = cnt_q + 24'd1;
                // A real completion takes precedence over a coincident timeout.
                if (tx_done || timeout_hit) begin
                    send_go_d      = 1'b0;
                    grant_d        = '0;
                    done_d[last_q] = 1'b1;
                    timeout_err_d  = !tx_done;
                    state_d        = GAP;
                end
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            done_q        <= '0;
            tx_data_q     <= 8'h00;
            send_go_q     <= 1'b0;
            timeout_err_q <= 1'b0;
            last_q        <= LAST_RST;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            done_q        <= done_d;
            tx_data_q     <= tx_data_d;
            send_go_q     <= send_go_d;
            timeout_err_q <= timeout_err_d;
            last_q        <= last_d;
            cnt_q         <= cnt_d;
        end
    end

    assign grant       = grant_q;
    assign done        = done_q;
    assign tx_data     = tx_data_q;
    assign send_go     = send_go_q;
    assign timeout_err = timeout_err_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single `uart_byte_tx` transmitter among up to `NUM_REQ` byte producers: the RX echo path, the `uart_cmd` acknowledgement path, and status reporters. It arbitrates round-robin and latches the winner's byte. It drives the transmitter's level-sensitive `Send_Go` until `Tx_done`, then returns a per-requester completion pulse. It sits between the producers and `uart_byte_tx`, replacing the ad-hoc `Rx_done`/`Tx_done` enable flop used in the echo top level.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `TIMEOUT_CYC`, 1000000: maximum clk cycles in SEND before abort. 0 disables the timeout. Must be < 2^24.
- `clk` in 1: system clock.
- `n_reset` in 1: reset, asynchronous, active-low.
- `req` in NUM_REQ: per-requester byte request, level.
- `req_data` in 8*NUM_REQ: requester i byte at [8i+7:8i].
- `grant` out NUM_REQ: one-hot; the active requester, held for the whole transfer.
- `done` out NUM_REQ: one-cycle pulse to the granted requester when its byte completes or aborts.
- `tx_data` out 8: to `uart_byte_tx.Data`. Registered; stable while `send_go`=1.
- `send_go` out 1: to `uart_byte_tx.Send_Go`.
- `tx_done` in 1: from `uart_byte_tx.Tx_done`, one-cycle pulse.
- `timeout_err` out 1: one-cycle pulse on a timeout abort.
- `busy` out 1: high when state ≠ IDLE.

## Operation
- **States:** IDLE, SEND, GAP. Reset state is IDLE.
- **IDLE:**
  - If `req` ≠ 0, select the winner by round-robin, starting the search at index `last+1` and wrapping modulo NUM_REQ.
  - Register `grant` = one-hot(winner), `tx_data` = `req_data[winner]`, `send_go`=1, and `last`=winner.
  - Clear the timeout counter and go to SEND.
- **SEND:**
  - The counter increments each cycle.
  - On `tx_done`: `send_go`<=0, `grant`<=0, `done[winner]`<=1, go to GAP.
  - Else, if TIMEOUT_CYC≠0 and counter == TIMEOUT_CYC-1: same actions as `tx_done`, plus `timeout_err`<=1.
  - If `tx_done` and the timeout hit occur in the same cycle, `tx_done` wins and `timeout_err` stays 0.
- **GAP:** exactly one cycle with `send_go`=0, guaranteeing the transmitter sees a falling edge. Then go to IDLE.
- **Requester contract:**
  - Hold `req` until `done[i]`.
  - Dropping `req` before grant withdraws the request with no side effects.
  - After grant, `req` and `req_data[i]` are ignored, because the byte is already latched.
  - Keeping `req` high after `done` requests the next byte; it re-enters arbitration normally.
- **Ignored events:**
  - `tx_done` in IDLE or GAP is ignored; no `done` pulse.
  - `req` bits are ignored outside IDLE.
- **Round-robin pointer `last`:** resets to NUM_REQ-1, so requester 0 has highest priority after reset. It updates only on grant.
- **Timeout counter:** 24-bit, saturating behaviour unused since the abort occurs first. It is cleared on entry to SEND.

## Timing
- **Reset values:** `grant`=0, `done`=0, `tx_data`=0x00, `send_go`=0, `timeout_err`=0, `busy`=0, `last`=NUM_REQ-1.
- **Reset behaviour:** all outputs clear immediately on `n_reset` low, including mid-SEND. The byte in flight is abandoned and no `done` is issued.
- **Grant latency:** `req` sampled high in IDLE at edge T gives `grant`, `tx_data`, `send_go`, `busy` valid after edge T+1.
- **Completion latency:** `tx_done` high at edge T gives `done`=1 and `send_go`=0 after T+1. GAP is T+1..T+2, IDLE after T+2. The earliest next `send_go` is after T+3.
- **`done` and `timeout_err` alignment:** both are registered, one cycle wide, and coincide with `send_go` falling.
- **Timeout:** with `send_go` rising after edge S, abort outputs appear after edge S+TIMEOUT_CYC.

## Test plan
- **Single request:** `req`=0001, `req_data[7:0]`=0x41 → next cycle `grant`=0001, `send_go`=1, `tx_data`=0x41. Model `tx_done` 10 cycles later → `done`=0001 for 1 cycle, `send_go`=0, 1 GAP cycle, then `busy`=0.
- **All requesting:** `req`=1111 held, bytes 0x10/0x11/0x12/0x13 → transmitted order 0x10, 0x11, 0x12, 0x13, 0x10. Each `done` pulse goes to the matching requester.
- **Fairness:** `req[0]` held continuously, `req[2]` raised during requester 0's SEND → next grant is 0100, then 0001.
- **Timeout:** TIMEOUT_CYC=16, no `tx_done` → exactly 16 cycles after `send_go` rises, `timeout_err`=1, `done`=winner, `send_go`=0. Bench also drives `tx_done` on the 16th cycle in a second run → `timeout_err` stays 0.
- **Reset mid-transfer:** assert `n_reset`=0 mid-SEND → all outputs 0 asynchronously. Release with `req`=0110 → grant 0010, confirming the pointer reset.
- **Spurious and withdrawn:** `tx_done` pulse in IDLE → no `done`, `busy`=0. `req[3]` pulsed for 1 cycle while busy, then dropped → never granted.
